// File: rtl/mult_seq_if.sv
// Operand/result handshake bundle for the sequential multiplier.
// The master side drives operands and consumes the double-width product.
interface mult_seq_if #(
  parameter int WIDTH = 64
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               a_signed;
  logic               b_signed;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output in_valid, a, b, a_signed, b_signed, flush, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, a_signed, b_signed, flush, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/mult_seq.sv
// Multi-cycle sign-magnitude multiplier: retires RADIX_BITS multiplier bits per
// cycle into a double-width accumulator, then applies the sign once at the end.
module mult_seq #(
  parameter int WIDTH      = 64,
  parameter int RADIX_BITS = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  mult_seq_if.slave bus
);
  localparam int N  = WIDTH / RADIX_BITS;
  localparam int CW = $clog2(N + 1);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    a_sh;
  logic [PW-1:0]    partial;
  logic [PW-1:0]    product_q;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [CW-1:0]    cnt;
  logic             neg;
  logic             a_neg;
  logic             b_neg;

  // Magnitudes of the incoming operands; -2^(WIDTH-1) maps to 2^(WIDTH-1),
  // which still fits because the result is read as unsigned.
  always_comb begin
    a_neg   = bus.a_signed & bus.a[WIDTH-1];
    b_neg   = bus.b_signed & bus.b[WIDTH-1];
    a_abs   = a_neg ? -bus.a : bus.a;
    b_abs   = b_neg ? -bus.b : bus.b;
    partial = a_sh * PW'(b_mag[RADIX_BITS-1:0]);
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    bus.product   = product_q;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) state_nxt = CALC;
      end
      CALC: if (cnt == CW'(1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // The multiplicand is pre-shifted each step so every partial product lands
  // in place without a variable shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      a_sh      <= '0;
      b_mag     <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && !bus.flush) begin
            a_sh  <= {{WIDTH{1'b0}}, a_abs};
            b_mag <= b_abs;
            neg   <= a_neg ^ b_neg;
            acc   <= '0;
            cnt   <= CW'(N);
          end
        end
        CALC: begin
          acc   <= acc + partial;
          a_sh  <= a_sh << RADIX_BITS;
          b_mag <= b_mag >> RADIX_BITS;
          cnt   <= cnt - CW'(1);
        end
        FIX: begin
          if (!bus.flush) product_q <= neg ? -acc : acc;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_seq.sv
// Randomized self-checking bench for mult_seq, compared against plain signed
// arithmetic; also exercises the 32/1 and 64/4 parameterisations.
module tb_mult_seq;
  logic clk = 1'b0;
  logic rst_n;
  logic start_par = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mult_seq_if #(.WIDTH(64)) bus ();
  mult_seq #(.WIDTH(64), .RADIX_BITS(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: interpret each operand as a mathematical integer, multiply, keep 2w bits.
  function automatic logic [127:0] refMul(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic as, input logic bs);
    logic signed [127:0] ea;
    logic signed [127:0] eb;
    logic signed [127:0] p;
    logic [127:0]        mask;
    ea = '0;
    eb = '0;
    for (int i = 0; i < w; i++) begin
      ea[i] = a[i];
      eb[i] = b[i];
    end
    if (as && a[w-1]) ea = ea - (128'sd1 <<< w);
    if (bs && b[w-1]) eb = eb - (128'sd1 <<< w);
    p    = ea * eb;
    mask = (w == 64) ? '1 : ((128'd1 << (2 * w)) - 128'd1);
    return p & mask;
  endfunction

  task automatic startOp(input logic [63:0] ta, input logic [63:0] tb, input logic tas, input logic tbs);
    int guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    bus.a        = ta;
    bus.b        = tb;
    bus.a_signed = tas;
    bus.b_signed = tbs;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = {$urandom(), $urandom()};
    bus.b        = {$urandom(), $urandom()};
    bus.a_signed = 1'($urandom_range(0, 1));
    bus.b_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic applyStimulus(input logic [63:0] ta, input logic [63:0] tb, input logic tas,
                               input logic tbs, output logic [127:0] res, output int lat);
    startOp(ta, tb, tas, tbs);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = bus.product;
  endtask

  task automatic drainResult();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkOutput("ready_after_release", 128'(bus.in_ready), 128'd1);
  endtask

  task automatic runCheck(input string tag, input logic [63:0] ta, input logic [63:0] tb,
                          input logic tas, input logic tbs, input logic [127:0] exp);
    logic [127:0] res;
    int           lat;
    applyStimulus(ta, tb, tas, tbs, res, lat);
    checkOutput(tag, res, exp);
    checkOutput({tag, "_lat"}, 128'(lat), 128'd33);
    drainResult();
  endtask

  task automatic watchNoValid(input string tag);
    int seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    checkOutput(tag, 128'(seen), 128'd0);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_par
    localparam int W = (g == 0) ? 32 : 64;
    localparam int R = (g == 0) ? 1 : 4;

    mult_seq_if #(.WIDTH(W)) pbus ();
    mult_seq #(.WIDTH(W), .RADIX_BITS(R)) pdut (.clk(clk), .rst_n(rst_n), .bus(pbus.slave));

    logic [63:0]  opa  [12];
    logic [63:0]  opb  [12];
    logic         opas [12];
    logic         opbs [12];
    logic [127:0] got  [12];
    int           lat  [12];
    logic         blk_done = 1'b0;

    initial begin
      logic [63:0] ra;
      logic [63:0] rb;
      int          n;
      pbus.in_valid  = 1'b0;
      pbus.a         = '0;
      pbus.b         = '0;
      pbus.a_signed  = 1'b0;
      pbus.b_signed  = 1'b0;
      pbus.flush     = 1'b0;
      pbus.out_ready = 1'b0;
      wait (start_par);
      for (int i = 0; i < 12; i++) begin
        ra      = {$urandom(), $urandom()} >> (64 - W);
        rb      = {$urandom(), $urandom()} >> (64 - W);
        opas[i] = 1'($urandom_range(0, 1));
        opbs[i] = 1'($urandom_range(0, 1));
        if (i == 0) begin
          ra      = 64'd1 << (W - 1);
          rb      = ra;
          opas[i] = 1'b1;
          opbs[i] = 1'b1;
        end
        opa[i] = ra;
        opb[i] = rb;
        @(negedge clk);
        pbus.a        = ra[W-1:0];
        pbus.b        = rb[W-1:0];
        pbus.a_signed = opas[i];
        pbus.b_signed = opbs[i];
        pbus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pbus.in_valid = 1'b0;
        n = 0;
        while (!pbus.out_valid && n < 100) begin
          @(posedge clk);
          n++;
          @(negedge clk);
        end
        lat[i] = n;
        got[i] = 128'(pbus.product);
        pbus.out_ready = 1'b1;
        @(negedge clk);
        pbus.out_ready = 1'b0;
      end
      blk_done = 1'b1;
    end
  end

  initial begin
    logic [127:0] res;
    logic [127:0] exp;
    logic [63:0]  ra;
    logic [63:0]  rb;
    logic         ras;
    logic         rbs;
    int           lat;
    int           guard;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.a_signed  = 1'b0;
    bus.b_signed  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", 128'(bus.in_ready), 128'd1);
    checkOutput("rst_out_valid", 128'(bus.out_valid), 128'd0);
    checkOutput("rst_busy", 128'(bus.busy), 128'd0);
    checkOutput("rst_product", bus.product, 128'd0);
    rst_n = 1'b1;

    runCheck("uns_ones", '1, '1, 1'b0, 1'b0, 128'hFFFFFFFFFFFFFFFE_0000000000000001);
    runCheck("ss_ones", '1, '1, 1'b1, 1'b1, 128'd1);
    runCheck("su_ones", '1, '1, 1'b1, 1'b0, 128'hFFFFFFFFFFFFFFFF_0000000000000001);
    runCheck("minneg_sq", 64'h8000000000000000, 64'h8000000000000000, 1'b1, 1'b1,
             128'h40000000000000000000000000000000);
    runCheck("minneg_x1", 64'h8000000000000000, 64'd1, 1'b1, 1'b0,
             128'hFFFFFFFFFFFFFFFF_8000000000000000);

    // Backpressure: result must hold while in_valid pulses are ignored.
    exp = refMul(64, 64'd123456789, 64'd987654321, 1'b0, 1'b0);
    applyStimulus(64'd123456789, 64'd987654321, 1'b0, 1'b0, res, lat);
    checkOutput("bp_prod", res, exp);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'(i % 2);
      checkOutput("bp_valid", 128'(bus.out_valid), 128'd1);
      checkOutput("bp_hold", bus.product, exp);
    end
    bus.in_valid = 1'b0;
    drainResult();
    @(negedge clk);
    checkOutput("bp_no_capture", 128'(bus.busy), 128'd0);
    checkOutput("bp_retain", bus.product, exp);

    for (int i = 0; i < 6; i++) begin
      ra  = {$urandom(), $urandom()};
      rb  = {$urandom(), $urandom()};
      ras = 1'($urandom_range(0, 1));
      rbs = 1'($urandom_range(0, 1));
      runCheck("stream", ra, rb, ras, rbs, refMul(64, ra, rb, ras, rbs));
    end

    startOp(64'd11, 64'd13, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checkOutput("flush_calc_busy", 128'(bus.busy), 128'd0);
    checkOutput("flush_calc_ready", 128'(bus.in_ready), 128'd1);
    watchNoValid("flush_calc_novalid");

    bus.a        = 64'd21;
    bus.b        = 64'd2;
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    checkOutput("flush_idle_busy", 128'(bus.busy), 128'd0);
    watchNoValid("flush_idle_novalid");

    applyStimulus(64'd7, 64'd9, 1'b0, 1'b0, res, lat);
    checkOutput("flush_done_prod", res, 128'd63);
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    checkOutput("flush_done_valid", 128'(bus.out_valid), 128'd0);
    checkOutput("flush_done_ready", 128'(bus.in_ready), 128'd1);

    startOp(64'd100, 64'd200, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready", 128'(bus.in_ready), 128'd1);
    checkOutput("midrst_out_valid", 128'(bus.out_valid), 128'd0);
    checkOutput("midrst_busy", 128'(bus.busy), 128'd0);
    checkOutput("midrst_product", bus.product, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    runCheck("after_reset", 64'd3, 64'd5, 1'b0, 1'b0, 128'd15);

    for (int i = 0; i < 20; i++) begin
      ra  = {$urandom(), $urandom()};
      rb  = {$urandom(), $urandom()};
      ras = 1'($urandom_range(0, 1));
      rbs = 1'($urandom_range(0, 1));
      if (i % 5 == 0) rb = 64'(rb[7:0]);
      runCheck("rand64", ra, rb, ras, rbs, refMul(64, ra, rb, ras, rbs));
    end

    start_par = 1'b1;
    guard = 0;
    while (!(g_par[0].blk_done && g_par[1].blk_done) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("param_done", 128'({g_par[0].blk_done, g_par[1].blk_done}), 128'd3);
    for (int i = 0; i < 12; i++) begin
      checkOutput("w32r1_prod", g_par[0].got[i],
                  refMul(32, g_par[0].opa[i], g_par[0].opb[i], g_par[0].opas[i], g_par[0].opbs[i]));
      checkOutput("w32r1_lat", 128'(g_par[0].lat[i]), 128'd33);
      checkOutput("w64r4_prod", g_par[1].got[i],
                  refMul(64, g_par[1].opa[i], g_par[1].opb[i], g_par[1].opas[i], g_par[1].opbs[i]));
      checkOutput("w64r4_lat", 128'(g_par[1].lat[i]), 128'd17);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
